pc_gen: RTL

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen.sv | 103 ++++++++++
 1 files changed

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator with BOOT/RUN/HALT control, prioritised
// redirect channels and a saturating count of redirects taken.
// Optional feature: define PC_GEN_ALIGN_CHK_EN to reject redirects whose
// target has bits [1:0] != 0. A rejected target sends the block to HALT and
// pulses misalign_err for one cycle.
module pc_gen #(
  parameter int                XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
  parameter int                NUM_REDIR    = 3,
  parameter int                STEP         = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stop,
  input  logic [NUM_REDIR-1:0]      redir_valid,
  input  logic [NUM_REDIR*XLEN-1:0] redir_target,
  input  logic                      halt_req,
  input  logic                      resume,
  output logic                      fetch_valid,
  input  logic                      fetch_ready,
  output logic [XLEN-1:0]           fetch_pc,
  output logic                      halted,
`ifdef PC_GEN_ALIGN_CHK_EN
  output logic                      misalign_err,
`endif
  output logic [15:0]               redir_cnt
);

  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            armed_q;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] sel_tgt;
  logic            redir_take;
  logic            bad_tgt;

  // Lowest-index asserted channel wins: scan from the top so index 0 lands last.
  always_comb begin
    sel_tgt = '0;
    for (int i = NUM_REDIR - 1; i >= 0; i--) begin
      if (redir_valid[i]) sel_tgt = redir_target[i*XLEN +: XLEN];
    end
  end

  // Redirects are only honoured once BOOT is over.
  assign redir_take = (|redir_valid) && (state_q != BOOT);

`ifdef PC_GEN_ALIGN_CHK_EN
  assign bad_tgt      = redir_take && (sel_tgt[1:0] != 2'b00);
  assign misalign_err = mis_q;
`else
  assign bad_tgt = 1'b0;
`endif

  // Next-state, next-PC and redirect counter.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    mis_d   = bad_tgt;
    unique case (state_q)
      BOOT:    if (armed_q) state_d = RUN;
      RUN:     if (halt_req) state_d = HALT;
      HALT:    if (resume && !halt_req) state_d = RUN;
      default: state_d = BOOT;
    endcase
    if (redir_take) begin
      // A rejected target keeps the PC and parks the block in HALT.
      if (bad_tgt) state_d = HALT;
      else         pc_d    = sel_tgt;
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end else if (state_q == RUN && fetch_ready && !stop) begin
      pc_d = pc_q + XLEN'(STEP);
    end
  end

  // State registers; reset loads the boot vector and clears everything else.
  // armed_q marks the first edge after release so BOOT spans one full cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      armed_q <= 1'b1;
      mis_q   <= mis_d;
    end
  end

  assign fetch_valid = (state_q == RUN);
  assign halted      = (state_q == HALT);
  assign fetch_pc    = pc_q;
  assign redir_cnt   = cnt_q;

endmodule
